// File: rtl/qspa_pkg.sv
// Shared types and sizes for the QSP pipeline: opcode, register addressing and
// the execute-slot payload handed from issue to execute.
package qspa_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_REGS   = 16;
  localparam int REG_ADDR_W = 4;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SLL = 3'd6,
    OP_SRL = 3'd7
  } op_t;

  typedef struct packed {
    op_t                   op;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
  } ex_slot_t;

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy vector: one bit per architectural register, set when a writer
// enters execute, cleared by its writeback or when a flush kills it before
// execute accepted it. r0 is hard-wired to never be busy.
module issue_scoreboard
  import qspa_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next busy vector: clears first so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en)  busy_d[clr_addr]  = 1'b0;
    if (kill_en) busy_d[kill_addr] = 1'b0;
    if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
  end

  // Busy vector register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
  assign rd_busy  = busy_q[rd_addr];

endmodule

// File: rtl/issue_stage.sv
// Issue stage: resolves operands of the instruction held in the dec/iss slot
// (capture, writeback bypass, decode-time read), stalls decode on RAW/WAW or a
// full execute slot, and drives a registered valid/ready slot to execute.
module issue_stage
  import qspa_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  op_t                   iss_alu_op,
  input  logic [REG_ADDR_W-1:0] iss_rd_addr,
  input  logic [REG_ADDR_W-1:0] iss_rs1_addr,
  input  logic [REG_ADDR_W-1:0] iss_rs2_addr,
  input  logic                  iss_we,
  input  logic                  iss_use_imm,
  input  logic [DATA_WIDTH-1:0] iss_imm_ext,
  input  logic [DATA_WIDTH-1:0] iss_rs1_data,
  input  logic [DATA_WIDTH-1:0] iss_rs2_data,
  output logic                  iss_stall,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ex_ready,
  output logic                  ex_valid,
  output op_t                   ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_we,
  output logic [DATA_WIDTH-1:0] ex_op_a,
  output logic [DATA_WIDTH-1:0] ex_op_b
);

  logic                  slot_vld, issue;
  logic                  rs1_busy, rs2_busy, rd_busy;
  logic                  wb_hit_a, wb_hit_b, wb_hit_rd;
  logic                  a_ok, b_ok, raw, waw, full;
  logic [DATA_WIDTH-1:0] opnd_a, opnd_b;
  logic                  cap_a_vld_q, cap_a_vld_d, cap_b_vld_q, cap_b_vld_d;
  logic [DATA_WIDTH-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d;
  ex_slot_t              ex_q, ex_d;
  logic                  ex_valid_q, ex_valid_d;

  assign slot_vld  = (iss_alu_op != NOP);
  assign wb_hit_a  = wb_valid && (wb_rd_addr == iss_rs1_addr);
  assign wb_hit_b  = wb_valid && (wb_rd_addr == iss_rs2_addr);
  assign wb_hit_rd = wb_valid && (wb_rd_addr == iss_rd_addr);

  issue_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue && iss_we),
    .set_addr  (iss_rd_addr),
    .clr_en    (wb_valid),
    .clr_addr  (wb_rd_addr),
    .kill_en   (flush && ex_valid_q && ex_q.we),
    .kill_addr (ex_q.rd),
    .rs1_addr  (iss_rs1_addr),
    .rs2_addr  (iss_rs2_addr),
    .rd_addr   (iss_rd_addr),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .rd_busy   (rd_busy)
  );

  // Operand resolution: captured value, then bypass, then busy, then decode read.
  always_comb begin
    opnd_a = iss_rs1_data;
    a_ok   = 1'b1;
    if (cap_a_vld_q)   opnd_a = cap_a_q;
    else if (wb_hit_a) opnd_a = wb_data;
    else if (rs1_busy) a_ok   = 1'b0;

    opnd_b = iss_rs2_data;
    b_ok   = 1'b1;
    if (iss_use_imm)       opnd_b = iss_imm_ext;
    else if (cap_b_vld_q)  opnd_b = cap_b_q;
    else if (wb_hit_b)     opnd_b = wb_data;
    else if (rs2_busy)     b_ok   = 1'b0;
  end

  assign raw       = slot_vld && !(a_ok && b_ok);
  assign waw       = slot_vld && iss_we && rd_busy && !wb_hit_rd;
  assign full      = ex_valid_q && !ex_ready;
  assign iss_stall = !flush && slot_vld && (raw || waw || full);
  assign issue     = slot_vld && !iss_stall && !flush;

  // Capture next state: flags drop when the slot advances or on flush; while
  // stalled, a matching writeback is latched so it outlives the bypass cycle.
  always_comb begin
    cap_a_vld_d = cap_a_vld_q;
    cap_a_d     = cap_a_q;
    cap_b_vld_d = cap_b_vld_q;
    cap_b_d     = cap_b_q;
    if (flush || !iss_stall) begin
      cap_a_vld_d = 1'b0;
      cap_b_vld_d = 1'b0;
    end else begin
      if (wb_hit_a) begin
        cap_a_vld_d = 1'b1;
        cap_a_d     = wb_data;
      end
      if (wb_hit_b) begin
        cap_b_vld_d = 1'b1;
        cap_b_d     = wb_data;
      end
    end
  end

  // Capture registers; only the flags need a reset value.
  always_ff @(posedge clk) begin
    cap_a_q <= cap_a_d;
    cap_b_q <= cap_b_d;
    if (rst) begin
      cap_a_vld_q <= 1'b0;
      cap_b_vld_q <= 1'b0;
    end else begin
      cap_a_vld_q <= cap_a_vld_d;
      cap_b_vld_q <= cap_b_vld_d;
    end
  end

  // Ex slot next state: flush kills, issue loads, accepted slot empties.
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
      ex_d.op    = NOP;
    end else if (issue) begin
      ex_valid_d = 1'b1;
      ex_d.op    = iss_alu_op;
      ex_d.rd    = iss_rd_addr;
      ex_d.we    = iss_we;
      ex_d.op_a  = opnd_a;
      ex_d.op_b  = opnd_b;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
      ex_d.op    = NOP;
    end
  end

  // Ex slot register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q.op    <= NOP;
      ex_q.rd    <= '0;
      ex_q.we    <= 1'b0;
      ex_q.op_a  <= '0;
      ex_q.op_b  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_alu_op  = ex_q.op;
  assign ex_rd_addr = ex_q.rd;
  assign ex_we      = ex_q.we;
  assign ex_op_a    = ex_q.op_a;
  assign ex_op_b    = ex_q.op_b;

endmodule

// File: tb/tb_issue_stage.sv
// Random-stream bench for issue_stage. The bench plays decode (with a write-first
// register file), execute (random ready, delayed in-order writebacks) and flush.
// Expected operands come from program order: each instruction must see the
// value of the latest surviving older writer of its source register.
module tb_issue_stage;
  import qspa_pkg::*;

  localparam int NINSTR = 400;

  logic        clk = 1'b0;
  logic        rst, flush;
  op_t         iss_alu_op;
  logic [3:0]  iss_rd_addr, iss_rs1_addr, iss_rs2_addr;
  logic        iss_we, iss_use_imm;
  logic [31:0] iss_imm_ext, iss_rs1_data, iss_rs2_data;
  logic        iss_stall;
  logic        wb_valid;
  logic [3:0]  wb_rd_addr;
  logic [31:0] wb_data;
  logic        ex_ready, ex_valid;
  op_t         ex_alu_op;
  logic [3:0]  ex_rd_addr;
  logic        ex_we;
  logic [31:0] ex_op_a, ex_op_b;

  always #5 clk = ~clk;

  issue_stage u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_alu_op(iss_alu_op), .iss_rd_addr(iss_rd_addr), .iss_rs1_addr(iss_rs1_addr),
    .iss_rs2_addr(iss_rs2_addr), .iss_we(iss_we), .iss_use_imm(iss_use_imm),
    .iss_imm_ext(iss_imm_ext), .iss_rs1_data(iss_rs1_data), .iss_rs2_data(iss_rs2_data),
    .iss_stall(iss_stall), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_rd_addr(ex_rd_addr),
    .ex_we(ex_we), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b)
  );

  typedef struct {
    op_t         op;
    logic [3:0]  rd, rs1, rs2;
    logic        we, use_imm;
    logic [31:0] imm, d1, d2, a, b, res;
  } instr_t;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
    int          due;
  } wb_t;

  instr_t      exp_q[$];
  wb_t         wb_q[$];
  logic [31:0] rf[16], lastval[16], xferval[16];
  int          total = 0, bad = 0, cyc = 0, created = 0;
  bit          mon_en = 1'b0;

  instr_t cur, mrec;
  bit     slot_nn, ex_occ, ex_we_m, fl, wbv, haz, exp_stall, issue_m, done;
  logic [3:0] ex_rd_m;
  wb_t    w, nw;
  bit     pend[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_slot();
    if (slot_nn) begin
      iss_alu_op = cur.op;      iss_rd_addr = cur.rd;
      iss_rs1_addr = cur.rs1;   iss_rs2_addr = cur.rs2;
      iss_we = cur.we;          iss_use_imm = cur.use_imm;
      iss_imm_ext = cur.imm;    iss_rs1_data = cur.d1;  iss_rs2_data = cur.d2;
    end else begin
      iss_alu_op = NOP;         iss_rd_addr = '0;
      iss_rs1_addr = '0;        iss_rs2_addr = '0;
      iss_we = 1'b0;            iss_use_imm = 1'b0;
      iss_imm_ext = '0;         iss_rs1_data = '0;      iss_rs2_data = '0;
    end
  endtask

  // New instruction entering the slot; decode reads rf (already write-first).
  task automatic new_instr();
    cur.op      = op_t'(3'(1 + $urandom % 7));
    cur.we      = ($urandom % 4) != 0;
    cur.rd      = cur.we ? 4'(1 + $urandom % 5) : 4'($urandom % 6);
    cur.rs1     = 4'($urandom % 6);
    cur.rs2     = 4'($urandom % 6);
    cur.use_imm = ($urandom % 10) < 3;
    cur.imm     = $urandom;
    cur.d1      = rf[cur.rs1];
    cur.d2      = rf[cur.rs2];
    cur.a       = lastval[cur.rs1];
    cur.b       = cur.use_imm ? cur.imm : lastval[cur.rs2];
    cur.res     = $urandom;
    if (cur.we) lastval[cur.rd] = cur.res;
    exp_q.push_back(cur);
    created++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ex_valid"}, 64'(ex_valid), 64'(0));
    check({tag, "_ex_alu_op"}, 64'(ex_alu_op), 64'(NOP));
    check({tag, "_ex_rd"}, 64'(ex_rd_addr), 64'(0));
    check({tag, "_ex_we"}, 64'(ex_we), 64'(0));
    check({tag, "_ex_op_a"}, 64'(ex_op_a), 64'(0));
    check({tag, "_ex_op_b"}, 64'(ex_op_b), 64'(0));
    check({tag, "_iss_stall"}, 64'(iss_stall), 64'(0));
    check({tag, "_busy"}, 64'(u_dut.u_sb.busy_q), 64'(0));
  endtask

  // Monitor: on every transfer pop the oldest expectation and compare; also
  // checks that a held slot does not change while execute back-pressures.
  op_t         p_op;
  logic [3:0]  p_rd;
  logic        p_we;
  logic [31:0] p_a, p_b;
  bit          prv_hold = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prv_hold) begin
        check("hold_valid", 64'(ex_valid), 64'(1));
        check("hold_op", 64'(ex_alu_op), 64'(p_op));
        check("hold_rd", 64'(ex_rd_addr), 64'(p_rd));
        check("hold_we", 64'(ex_we), 64'(p_we));
        check("hold_a", 64'(ex_op_a), 64'(p_a));
        check("hold_b", 64'(ex_op_b), 64'(p_b));
      end
      prv_hold = ex_valid && !ex_ready && !flush;
      p_op = ex_alu_op; p_rd = ex_rd_addr; p_we = ex_we; p_a = ex_op_a; p_b = ex_op_b;
      if (ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_transfer: got op %0d with no instruction pending", ex_alu_op);
        end else begin
          mrec = exp_q.pop_front();
          check("xfer_op", 64'(ex_alu_op), 64'(mrec.op));
          check("xfer_rd", 64'(ex_rd_addr), 64'(mrec.rd));
          check("xfer_we", 64'(ex_we), 64'(mrec.we));
          check("xfer_op_a", 64'(ex_op_a), 64'(mrec.a));
          check("xfer_op_b", 64'(ex_op_b), 64'(mrec.b));
          if (mrec.we) begin
            nw.rd   = mrec.rd;
            nw.data = mrec.res;
            nw.due  = cyc + 1 + int'($urandom % 4);
            wb_q.push_back(nw);
            xferval[mrec.rd] = mrec.res;
          end
        end
      end
    end else begin
      prv_hold = 1'b0;
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
    wb_valid = 1'b0; wb_rd_addr = '0; wb_data = '0;
    slot_nn = 1'b0; ex_occ = 1'b0; ex_we_m = 1'b0; ex_rd_m = '0; done = 1'b0;
    drive_slot();
    for (int i = 0; i < 16; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    for (int i = 0; i < 16; i++) begin lastval[i] = rf[i]; xferval[i] = rf[i]; end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset_outputs("init");

    mon_en = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      cyc++;
      fl = (created < NINSTR) && (($urandom % 25) == 0);
      flush = fl;
      ex_ready = fl ? 1'b0 : (($urandom % 10) < 7);
      wbv = 1'b0;
      if (wb_q.size() > 0 && wb_q[0].due <= cyc) begin
        w = wb_q.pop_front();
        wbv = 1'b1;
      end
      wb_valid   = wbv;
      wb_rd_addr = wbv ? w.rd : 4'h0;
      wb_data    = wbv ? w.data : 32'h0;
      drive_slot();
      #1;

      // A register is pending when an older surviving writer has not yet
      // written back (and is not writing back this very cycle).
      for (int r = 0; r < 16; r++) pend[r] = 1'b0;
      foreach (wb_q[k]) pend[wb_q[k].rd] = 1'b1;
      if (ex_occ && ex_we_m) pend[ex_rd_m] = 1'b1;
      haz = pend[cur.rs1] || (!cur.use_imm && pend[cur.rs2]) || (cur.we && pend[cur.rd]);
      exp_stall = !fl && slot_nn && ((ex_occ && !ex_ready) || haz);
      check("iss_stall", 64'(iss_stall), 64'(exp_stall));
      check("ex_valid", 64'(ex_valid), 64'(ex_occ));

      issue_m = slot_nn && !iss_stall && !fl;
      if (fl) ex_occ = 1'b0;
      else if (issue_m) begin
        ex_occ = 1'b1; ex_we_m = cur.we; ex_rd_m = cur.rd;
      end else if (ex_ready) ex_occ = 1'b0;

      if (wbv) rf[w.rd] = w.data;
      if (fl) begin
        slot_nn = 1'b0;
        exp_q.delete();
        for (int r = 0; r < 16; r++) lastval[r] = xferval[r];
      end else if (!iss_stall) begin
        if (created < NINSTR && ($urandom % 4) != 0) begin
          new_instr();
          slot_nn = 1'b1;
        end else begin
          slot_nn = 1'b0;
        end
      end
      if (created >= NINSTR && !slot_nn && !ex_occ && exp_q.size() == 0 && wb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end

    @(posedge clk); #1;
    flush = 1'b0; wb_valid = 1'b0; ex_ready = 1'b0;
    drive_slot();
    #1;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d expectations and %0d writebacks left", exp_q.size(), wb_q.size());
    end
    check("busy_after_drain", 64'(u_dut.u_sb.busy_q), 64'(0));

    // Reset in the middle of a stall on a full execute slot.
    mon_en = 1'b0;
    @(posedge clk); #1;
    cur.op = OP_ADD; cur.rd = 4'd1; cur.we = 1'b1; cur.rs1 = 4'd0; cur.rs2 = 4'd0;
    cur.use_imm = 1'b0; cur.imm = 32'h0; cur.d1 = 32'h0; cur.d2 = 32'h0;
    slot_nn = 1'b1;
    drive_slot();
    @(posedge clk); #1;
    cur.op = OP_SUB; cur.rd = 4'd2;
    drive_slot();
    #1;
    check("pre_reset_stall", 64'(iss_stall), 64'(1));
    check("pre_reset_ex_valid", 64'(ex_valid), 64'(1));
    check("pre_reset_busy_r1", 64'(u_dut.u_sb.busy_q[1]), 64'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    slot_nn = 1'b0;
    drive_slot();
    #1 check_reset_outputs("midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
# issue_stage

Issue stage of the QSP pipeline, downstream of the decode/issue pipeline register and upstream of execute. It holds one decoded instruction, detects RAW/WAW hazards against a register scoreboard, and forwards writeback results into stale operands. It drives a registered issue slot to execute with a valid/ready handshake and back-pressures decode through `iss_stall`.

## Interface
- `DATA_WIDTH`, package `qspa_pkg`: operand width.
- `NUM_REGS`, default 16: architectural registers; address width 4.
- `clk  in  1`: clock.
- `rst  in  1`: synchronous, active-high reset.
- `flush  in  1`: squash; same signal drives the dec/iss register flush.
- `iss_alu_op  in  op_t`: instruction in slot; `NOP` means empty.
- `iss_rd_addr`, `iss_rs1_addr`, `iss_rs2_addr  in  4`: destination and source register numbers.
- `iss_we  in  1`: instruction writes `rd`.
- `iss_use_imm  in  1`: operand B is the immediate, so rs2 is ignored.
- `iss_imm_ext`, `iss_rs1_data`, `iss_rs2_data  in  DATA_WIDTH`: immediate and register values read at decode.
- `iss_stall  out  1`: combinational; holds the dec/iss register and decode.
- `wb_valid  in  1`: writeback write this cycle.
- `wb_rd_addr  in  4`: writeback destination.
- `wb_data  in  DATA_WIDTH`: writeback value.
- `ex_ready  in  1`: execute accepts the slot.
- `ex_valid  out  1`: issue slot valid.
- `ex_alu_op  out  op_t`: issued opcode.
- `ex_rd_addr  out  4`: issued destination.
- `ex_we  out  1`: issued write enable.
- `ex_op_a  out  DATA_WIDTH`: resolved operand A.
- `ex_op_b  out  DATA_WIDTH`: resolved operand B, or the immediate when `use_imm`.

## Operation
- Scoreboard: `busy[NUM_REGS]`. r0 is never set busy.
  - Set `busy[rd]` when an instruction with `we=1` moves into the ex slot.
  - Clear `busy[wb_rd_addr]` on `wb_valid`.
  - Set and clear of the same register in one cycle: set wins.
- Operand resolution for A (rs1) and B (rs2, only if `!use_imm`), in priority order:
  1. Captured value.
  2. `wb_valid && wb_rd_addr==rs`: use `wb_data` (bypass).
  3. `busy[rs]`: unresolved.
  4. `iss_rsX_data`.
- Capture:
  - While an instruction sits in the slot, any `wb_valid` matching rs1/rs2 latches `wb_data` into a per-operand capture register and sets its flag.
  - Capture flags clear when a new instruction enters the slot (cycle after `iss_stall=0`) and on flush.
  - The regfile is write-first, so the data read at decode already reflects writeback in the decode cycle.
- Hazards (slot non-`NOP`):
  - raw = an operand is unresolved.
  - waw = `we && busy[rd]` and not cleared by `wb` this cycle.
  - full = `ex_valid && !ex_ready`.
  - `iss_stall = !flush && (raw || waw || full)`.
  - A `NOP` slot never stalls.
- Issue: when the slot is non-`NOP`, `!iss_stall` and `!flush`, load the ex slot with op, rd, we and resolved operands, and set `ex_valid=1`. Otherwise, if `ex_ready`, set `ex_valid=0` and `ex_alu_op=NOP`.
- Flush (priority over issue):
  - Kills the ex slot regardless of `ex_ready`. If the killed entry had `we=1`, clear its `busy[rd]`.
  - Clears capture flags.
  - Scoreboard entries of instructions already accepted by execute are untouched; their writeback still clears them.
- Reset mid-operation: all state returns to reset values next edge; in-flight writebacks after reset are harmless (clear an already-clear bit).

## Timing
- Reset values:
  - `ex_valid=0`, `ex_alu_op=NOP`.
  - `ex_rd_addr=0`, `ex_we=0`, `ex_op_a=0`, `ex_op_b=0`.
  - `busy=0`, capture flags 0.
  - `iss_stall=0` after reset, because the slot is `NOP`.
- Latency: one cycle from an unstalled slot to the ex slot. Back-to-back issue is possible every cycle while `ex_ready=1`.
- Handshake: a transfer occurs on `ex_valid && ex_ready`. ex outputs are stable while `ex_valid && !ex_ready`.
- A writeback in cycle N resolves a RAW stall in cycle N via bypass; the instruction issues at edge N+1.

## Structure
- `qspa_pkg` gains `NUM_REGS`, `REG_ADDR_W=4` and an `ex_slot_t` struct (op, rd, we, op_a, op_b).
- Sub-module `issue_scoreboard`: busy vector with set/clear/kill ports and combinational busy lookups for rs1/rs2/rd. Operand capture and the ex slot stay in `issue_stage`.

## Test plan
- Independent stream: `ADD r1` then `ADD r2`, no hazards, `ex_ready=1` -> issued on consecutive cycles, `iss_stall` never 1.
- RAW: issue `r3=…` (busy), then `ADD r4,r3,r5`; `wb_valid`, `wb_rd=3`, `wb_data=0x5A` three cycles later -> stall for 3 cycles, then `ex_op_a=0x5A`, `busy[3]=0`.
- Capture: writeback r3=`0x11` while stalled on `ex_ready=0` -> after `ex_ready` rises, `ex_op_a=0x11`, not the stale decode value.
- WAW with simultaneous wb: r6 busy, new writer to r6 in slot, `wb_rd=6` the same cycle -> issues next edge, `busy[6]=1`.
- Flush of an unaccepted ex slot writing r7 -> `ex_valid=0`, `busy[7]=0` next cycle.
- Reset asserted mid-stall -> all outputs at reset values, `iss_stall=0`.
